// File: rtl/mean_ctrl_pkg.sv
// Shared types and constants for the 3x3 mean filter window sequencer.
package mean_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int DRAIN_CYCLES = 2;

    // Window taps, row-major from the top-left corner.
    localparam int WIN_TAPS      = 9;
    localparam int WIN_COLS      = 3;
    localparam int WIN_ROWS      = 3;
    localparam int WIN_TOP_RIGHT = 2;
    localparam int WIN_MID_RIGHT = 5;
    localparam int WIN_BOT_RIGHT = 8;

endpackage

// File: rtl/mean_window_ctrl_line_buffer.sv
// Two-line pixel history for the window sequencer: one word per column holding {lb1, lb0}.
module line_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mean_window_ctrl.sv
// Raster-to-3x3-window sequencer feeding mean_func and re-aligning its registered result.
// Optional FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module mean_window_ctrl
    import mean_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   pix_in,
    input  logic                    pix_valid,
    input  logic                    pix_sof,
    output logic                    pix_ready,
    output logic [9*DATA_WIDTH-1:0] win_bus,
    output logic                    mf_enable,
    input  logic [DATA_WIDTH-1:0]   mf_data,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    output logic                    out_eof,
    output logic                    sof_err
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0]             frame_cnt
`endif
);

    localparam int DW  = DATA_WIDTH;
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [CW-1:0]  COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
    logic [DW-1:0]   window_q [WIN_TAPS];
    logic [DW-1:0]   window_d [WIN_TAPS];

    logic            pix_ready_q, pix_ready_d;
    logic            mf_enable_q, mf_enable_d;
    logic            eof_pend_q, eof_pend_d;
    logic            out_valid_q, out_valid_d;
    logic            out_eof_q, out_eof_d;
    logic            sof_err_q, sof_err_d;

    logic            accept_s;
    logic            in_frame_s;
    logic            take_s;
    logic [CW-1:0]   cur_col_s;
    logic [RW-1:0]   cur_row_s;
    logic            col_end_s;
    logic            fill_done_s;
    logic            frame_last_s;
    logic            win_valid_s;
    logic            lb_we_s;
    logic [2*DW-1:0] lb_rdata_s;
    logic [2*DW-1:0] lb_wdata_s;

    // A pixel with pix_sof is always taken as (0,0), whatever the counters say.
    assign accept_s     = pix_valid & pix_ready_q;
    assign in_frame_s   = (state_q == FILL) || (state_q == RUN);
    assign take_s       = accept_s & (pix_sof | in_frame_s);
    assign cur_col_s    = pix_sof ? '0 : col_q;
    assign cur_row_s    = pix_sof ? '0 : row_q;
    assign col_end_s    = (cur_col_s == COL_LAST);
    assign fill_done_s  = take_s & ~pix_sof & (state_q == FILL) &
                          (cur_row_s == RW'(1)) & col_end_s;
    assign frame_last_s = take_s & ~pix_sof & (state_q == RUN) &
                          (cur_row_s == ROW_LAST) & col_end_s;
    assign win_valid_s  = take_s & (cur_row_s >= RW'(2)) & (cur_col_s >= CW'(2));
    assign lb_we_s      = take_s;
    assign lb_wdata_s   = {lb_rdata_s[DW-1:0], pix_in};

    line_buffer #(
        .WIDTH (2 * DW),
        .DEPTH (IMG_W),
        .AW    (CW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_we_s),
        .wr_addr (cur_col_s),
        .wr_data (lb_wdata_s),
        .rd_addr (cur_col_s),
        .rd_data (lb_rdata_s)
    );

    // State and control register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            drain_cnt_q <= '0;
            pix_ready_q <= 1'b1;
            mf_enable_q <= 1'b0;
            eof_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            drain_cnt_q <= drain_cnt_d;
            pix_ready_q <= pix_ready_d;
            mf_enable_q <= mf_enable_d;
            eof_pend_q  <= eof_pend_d;
            out_valid_q <= out_valid_d;
            out_eof_q   <= out_eof_d;
            sof_err_q   <= sof_err_d;
        end
    end

    // Window pixels carry no reset; they are fully refreshed before any valid window.
    always_ff @(posedge clk) begin
        window_q <= window_d;
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                if (take_s) begin
                    state_d = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL, RUN: begin
                if (take_s && pix_sof) begin
                    state_d = FILL;
                end else if (fill_done_s) begin
                    state_d = RUN;
                end else if (frame_last_s) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = IDLE;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                drain_cnt_d = '0;
            end
        endcase
    end

    // Raster counters and window shift on every taken pixel.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        window_d = window_q;
        if (take_s) begin
            if (frame_last_s) begin
                col_d = '0;
                row_d = '0;
            end else if (col_end_s) begin
                col_d = '0;
                row_d = cur_row_s + RW'(1);
            end else begin
                col_d = cur_col_s + CW'(1);
                row_d = cur_row_s;
            end
            for (int r = 0; r < WIN_ROWS; r++) begin
                window_d[r*WIN_COLS]     = window_q[r*WIN_COLS + 1];
                window_d[r*WIN_COLS + 1] = window_q[r*WIN_COLS + 2];
            end
            window_d[WIN_TOP_RIGHT] = lb_rdata_s[2*DW-1:DW];
            window_d[WIN_MID_RIGHT] = lb_rdata_s[DW-1:0];
            window_d[WIN_BOT_RIGHT] = pix_in;
        end else begin
            col_d = col_q;
        end
    end

    // Output strobes: enable at t+1, result valid (and eof) at t+2 alongside mf_data.
    always_comb begin
        pix_ready_d = (state_d != DRAIN);
        mf_enable_d = win_valid_s;
        eof_pend_d  = frame_last_s;
        out_valid_d = mf_enable_q;
        out_eof_d   = eof_pend_q;
        sof_err_d   = take_s & pix_sof & in_frame_s;
    end

    // Flatten the window register onto the bus.
    always_comb begin
        win_bus = '0;
        for (int k = 0; k < WIN_TAPS; k++) begin
            win_bus[k*DW +: DW] = window_q[k];
        end
    end

    assign pix_ready = pix_ready_q;
    assign mf_enable = mf_enable_q;
    assign out_valid = out_valid_q;
    assign out_eof   = out_eof_q;
    assign sof_err   = sof_err_q;
    assign out_data  = out_valid_q ? mf_data : '0;

`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Completed-frame counter, wraps naturally at 16 bits.
    always_comb begin
        if (out_eof_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_mean_window_ctrl.sv
// Directed bench for mean_window_ctrl (5x4 frames) with a behavioural mean_func attached.
module tb_mean_window_ctrl;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   pix_in;
    logic            pix_valid;
    logic            pix_sof;
    logic            pix_ready;
    logic [9*DW-1:0] win_bus;
    logic            mf_enable;
    logic [DW-1:0]   mf_data;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_eof;
    logic            sof_err;
`ifdef FRAME_CNT_EN
    logic [15:0]     frame_cnt;
`endif

    mean_window_ctrl #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .win_bus   (win_bus),
        .mf_enable (mf_enable),
        .mf_data   (mf_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_eof   (out_eof),
        .sof_err   (sof_err)
`ifdef FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural mean_func: registered floor(sum/9) on enable.
    logic [11:0] win_sum;
    always_comb begin
        win_sum = 12'd0;
        for (int k = 0; k < 9; k++) win_sum = win_sum + 12'(win_bus[k*DW +: DW]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mf_data <= '0;
        else if (mf_enable) mf_data <= 8'(win_sum / 12'd9);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] q_data[$];
    bit            q_eof[$];
    int            first_valid_cyc = -1;
    int            sof_err_cnt = 0;
    int            gap_viol = 0;
    bit            prev_accept = 1'b0;
    int            accept22_cyc = 0;
    int            n_pass = 0;
    int            n_total = 0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mf_enable && !prev_accept) gap_viol++;
        prev_accept = pix_valid && pix_ready;
        if (out_valid) begin
            q_data.push_back(out_data);
            q_eof.push_back(out_eof);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (sof_err) sof_err_cnt++;
    end

    function automatic logic [DW-1:0] pix_val(input int mode, input int r, input int c);
        if (mode == 0) return 8'd90;
        else if (mode == 1) return 8'(r * W + c);
        else return 8'd255;
    endfunction

    task automatic clear_mon();
        q_data.delete();
        q_eof.delete();
        first_valid_cyc = -1;
        sof_err_cnt = 0;
        gap_viol = 0;
    endtask

    task automatic send_pix(input logic [DW-1:0] v, input logic sof, input bit gap);
        int budget;
        if (gap) begin
            if ($urandom_range(0, 1) == 1) begin
                pix_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        pix_valid = 1'b1;
        pix_in    = v;
        pix_sof   = sof;
        budget = 0;
        while (!pix_ready && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 20) begin
            n_total++;
            $display("FAIL ready_timeout: pix_ready stayed 0 for %0d cycles, required 1", budget);
        end
        accept22_cyc = cyc;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input int mode, input bit gap);
        int a22;
        a22 = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pix(pix_val(mode, r, c), (r == 0 && c == 0), gap);
                if (r == 2 && c == 2) a22 = accept22_cyc;
            end
        end
        accept22_cyc = a22;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pix_in = '0; pix_valid = 1'b0; pix_sof = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (pix_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", pix_ready); else n_pass++;
        n_total++; if (mf_enable !== 1'b0) $display("FAIL reset_mf_enable: got %b want 0", mf_enable); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_eof !== 1'b0) $display("FAIL reset_out_eof: got %b want 0", out_eof); else n_pass++;
        n_total++; if (sof_err !== 1'b0) $display("FAIL reset_sof_err: got %b want 0", sof_err); else n_pass++;
        n_total++; if (out_data !== 8'd0) $display("FAIL reset_out_data: got %0d want 0", out_data); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_constant();
        clear_mon();
        send_frame(0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        n_total++; if (q_data.size() !== 6) $display("FAIL const_count: got %0d want 6", q_data.size()); else n_pass++;
        for (int i = 0; i < q_data.size(); i++) begin
            n_total++; if (q_data[i] !== 8'd90) $display("FAIL const_val[%0d]: got %0d want 90", i, q_data[i]); else n_pass++;
            n_total++; if (q_eof[i] !== (i == 5)) $display("FAIL const_eof[%0d]: got %b want %b", i, q_eof[i], (i == 5)); else n_pass++;
        end
        n_total++;
        if (first_valid_cyc - accept22_cyc !== 2)
            $display("FAIL const_latency: got %0d cycles want 2", first_valid_cyc - accept22_cyc);
        else n_pass++;
    endtask

    task automatic test_ramp(input bit gap);
        logic [DW-1:0] exp_v [6];
        exp_v = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
        clear_mon();
        send_frame(1, gap);
        repeat (8) @(posedge clk);
        #1;
        n_total++; if (q_data.size() !== 6) $display("FAIL ramp_count(gap=%0d): got %0d want 6", gap, q_data.size()); else n_pass++;
        for (int i = 0; i < q_data.size() && i < 6; i++) begin
            n_total++; if (q_data[i] !== exp_v[i]) $display("FAIL ramp_val[%0d](gap=%0d): got %0d want %0d", i, gap, q_data[i], exp_v[i]); else n_pass++;
            n_total++; if (q_eof[i] !== (i == 5)) $display("FAIL ramp_eof[%0d](gap=%0d): got %b want %b", i, gap, q_eof[i], (i == 5)); else n_pass++;
        end
        n_total++; if (gap_viol !== 0) $display("FAIL ramp_gap_enable(gap=%0d): got %0d stray enables want 0", gap, gap_viol); else n_pass++;
    endtask

    task automatic test_sof_midframe();
        logic [DW-1:0] exp_v [6];
        exp_v = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
        clear_mon();
        for (int p = 0; p < 2 * W + 1; p++) send_pix(8'd200, (p == 0), 1'b0);
        send_frame(1, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        n_total++; if (sof_err_cnt !== 1) $display("FAIL sof_err_pulse: got %0d pulses want 1", sof_err_cnt); else n_pass++;
        n_total++; if (q_data.size() !== 6) $display("FAIL sof_count: got %0d want 6", q_data.size()); else n_pass++;
        for (int i = 0; i < q_data.size() && i < 6; i++) begin
            n_total++; if (q_data[i] !== exp_v[i]) $display("FAIL sof_val[%0d]: got %0d want %0d", i, q_data[i], exp_v[i]); else n_pass++;
            n_total++; if (q_eof[i] !== (i == 5)) $display("FAIL sof_eof[%0d]: got %b want %b", i, q_eof[i], (i == 5)); else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        logic [DW-1:0] exp_v [6];
        exp_v = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
        clear_mon();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                send_pix(pix_val(1, r, c), (r == 0 && c == 0), 1'b0);
        pix_valid = 1'b1; pix_in = pix_val(1, 3, 0);
        rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (mf_enable !== 1'b0) $display("FAIL rst_mid_mf_enable: got %b want 0", mf_enable); else n_pass++;
        n_total++; if (pix_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", pix_ready); else n_pass++;
        n_total++; if (out_data !== 8'd0) $display("FAIL rst_mid_out_data: got %0d want 0", out_data); else n_pass++;
        pix_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        send_frame(1, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        n_total++; if (q_data.size() !== 6) $display("FAIL rst_mid_count: got %0d want 6", q_data.size()); else n_pass++;
        for (int i = 0; i < q_data.size() && i < 6; i++) begin
            n_total++; if (q_data[i] !== exp_v[i]) $display("FAIL rst_mid_val[%0d]: got %0d want %0d", i, q_data[i], exp_v[i]); else n_pass++;
        end
        n_total++; if (q_eof.size() == 6 && q_eof[5] !== 1'b1) $display("FAIL rst_mid_eof: got 0 want 1"); else n_pass++;
    endtask

    task automatic test_all_255();
        clear_mon();
        send_frame(2, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        n_total++; if (q_data.size() !== 6) $display("FAIL max_count: got %0d want 6", q_data.size()); else n_pass++;
        for (int i = 0; i < q_data.size(); i++) begin
            n_total++; if (q_data[i] !== 8'd255) $display("FAIL max_val[%0d]: got %0d want 255", i, q_data[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_v [6];
        int eofs;
        exp_v = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        send_frame(1, 1'b0);
        send_frame(1, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        n_total++; if (q_data.size() !== 12) $display("FAIL b2b_count: got %0d want 12", q_data.size()); else n_pass++;
        eofs = 0;
        for (int i = 0; i < q_data.size() && i < 12; i++) begin
            n_total++; if (q_data[i] !== exp_v[i % 6]) $display("FAIL b2b_val[%0d]: got %0d want %0d", i, q_data[i], exp_v[i % 6]); else n_pass++;
            if (q_eof[i]) eofs++;
        end
        n_total++; if (eofs !== 2) $display("FAIL b2b_eofs: got %0d want 2", eofs); else n_pass++;
`ifdef FRAME_CNT_EN
        n_total++; if (frame_cnt !== 16'd2) $display("FAIL frame_cnt: got %0d want 2", frame_cnt); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp(1'b0);
        test_ramp(1'b1);
        test_sof_midframe();
        test_reset_midframe();
        test_all_255();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
